// File: rtl/piso_serializer_if.sv
// Load/shift/serial-out bundle between a parallel producer and the serializer.
// The producer side drives the handshake and strobes; the serializer drives line and status.
interface piso_serializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  load_valid;
   logic                  load_ready;
   logic [DATA_WIDTH-1:0] data_in;
   logic                  shift_en;
   logic                  abort;
   logic                  data_out;
   logic                  frame_active;
   logic                  last_bit;
   logic                  done;

   modport master (
      output load_valid, data_in, shift_en, abort,
      input  load_ready, data_out, frame_active, last_bit, done
   );

   modport slave (
      input  load_valid, data_in, shift_en, abort,
      output load_ready, data_out, frame_active, last_bit, done
   );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one word per frame, one bit per shift_en strobe,
// with gapless reload on the last bit and a synchronous abort.
module piso_serializer #(
   parameter int   DATA_WIDTH = 8,
   parameter bit   LSB_FIRST  = 1'b0,
   parameter logic IDLE_LEVEL = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   piso_serializer_if.slave   bus
);
   localparam int CW = $clog2(DATA_WIDTH);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_shift;
   logic [CW-1:0]         r_cnt;
   logic                  r_done;

   state_t                w_state_next;
   logic [DATA_WIDTH-1:0] w_shift_next;
   logic [CW-1:0]         w_cnt_next;
   logic                  w_done_next;

   logic                  w_bit;
   logic [DATA_WIDTH-1:0] w_shifted;
   logic                  w_last;
   logic                  w_ready;
   logic                  w_accept;

   generate
      if (LSB_FIRST) begin : g_lsb
         assign w_bit     = r_shift[0];
         assign w_shifted = {1'b0, r_shift[DATA_WIDTH-1:1]};
      end else begin : g_msb
         assign w_bit     = r_shift[DATA_WIDTH-1];
         assign w_shifted = {r_shift[DATA_WIDTH-2:0], 1'b0};
      end
   endgenerate

   assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(DATA_WIDTH - 1));
   // Ready on the last strobed bit too, so a waiting word follows with no idle gap.
   assign w_ready  = !bus.abort && ((r_state == IDLE) || (w_last && bus.shift_en));
   assign w_accept = bus.load_valid && w_ready;

   always_comb begin
      w_state_next = r_state;
      w_shift_next = r_shift;
      w_cnt_next   = r_cnt;
      w_done_next  = 1'b0;
      if (bus.abort) begin
         w_state_next = IDLE;
         w_shift_next = '0;
         w_cnt_next   = '0;
      end else if (w_accept) begin
         w_state_next = SHIFT;
         w_shift_next = bus.data_in;
         w_cnt_next   = '0;
         w_done_next  = (r_state == SHIFT);
      end else if (r_state == SHIFT && bus.shift_en) begin
         w_shift_next = w_shifted;
         if (w_last) begin
            w_state_next = IDLE;
            w_cnt_next   = '0;
            w_done_next  = 1'b1;
         end else begin
            w_cnt_next = r_cnt + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_shift <= w_shift_next;
         r_cnt   <= w_cnt_next;
         r_done  <= w_done_next;
      end
   end

   assign bus.load_ready   = w_ready;
   assign bus.frame_active = (r_state == SHIFT);
   assign bus.data_out     = (r_state == SHIFT) ? w_bit : IDLE_LEVEL;
   assign bus.last_bit     = w_last;
   assign bus.done         = r_done;
endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: MSB/LSB order, back-to-back, strobe gaps,
// abort, asynchronous reset mid-frame and the two-bit word width.
module tb_piso_serializer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass = 0;

   always #5 clk = ~clk;

   piso_serializer_if #(.DATA_WIDTH(8)) if_m ();
   piso_serializer_if #(.DATA_WIDTH(8)) if_l ();
   piso_serializer_if #(.DATA_WIDTH(2)) if_w ();

   piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_msb (
      .clk(clk), .reset(reset), .bus(if_m));
   piso_serializer #(.DATA_WIDTH(8), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_lsb (
      .clk(clk), .reset(reset), .bus(if_l));
   piso_serializer #(.DATA_WIDTH(2), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_w2 (
      .clk(clk), .reset(reset), .bus(if_w));

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      if_m.load_valid = 0; if_m.data_in = '0; if_m.shift_en = 0; if_m.abort = 0;
      if_l.load_valid = 0; if_l.data_in = '0; if_l.shift_en = 0; if_l.abort = 0;
      if_w.load_valid = 0; if_w.data_in = '0; if_w.shift_en = 0; if_w.abort = 0;
      reset = 1;
      cycle();
      n_checks++;
      if ({if_m.data_out, if_m.frame_active, if_m.last_bit, if_m.done} !== 4'b1000)
         $display("FAIL reset_msb: got %b expected 1000",
                  {if_m.data_out, if_m.frame_active, if_m.last_bit, if_m.done});
      else n_pass++;
      n_checks++;
      if ({if_l.data_out, if_l.frame_active, if_l.last_bit, if_l.done} !== 4'b1000)
         $display("FAIL reset_lsb: got %b expected 1000",
                  {if_l.data_out, if_l.frame_active, if_l.last_bit, if_l.done});
      else n_pass++;
      reset = 0;
      #1;
      n_checks++;
      if (if_m.load_ready !== 1'b1)
         $display("FAIL reset_ready: got %b expected 1", if_m.load_ready);
      else n_pass++;
      $display("reset released, load_ready=%b", if_m.load_ready);
   endtask

   task automatic test_msb_basic();
      logic [7:0] exp_seq = 8'b00000001;
      if_m.load_valid = 1; if_m.data_in = 8'h01; if_m.shift_en = 1;
      n_checks++;
      if (if_m.load_ready !== 1'b1)
         $display("FAIL msb_ready: got %b expected 1", if_m.load_ready);
      else n_pass++;
      cycle();
      if_m.load_valid = 0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if ({if_m.data_out, if_m.last_bit, if_m.done, if_m.frame_active} !==
             {exp_seq[7-i], (i == 7), 1'b0, 1'b1})
            $display("FAIL msb_bit%0d: got %b expected %b", i,
                     {if_m.data_out, if_m.last_bit, if_m.done, if_m.frame_active},
                     {exp_seq[7-i], (i == 7), 1'b0, 1'b1});
         else n_pass++;
         cycle();
      end
      n_checks++;
      if ({if_m.done, if_m.data_out, if_m.frame_active} !== 3'b110)
         $display("FAIL msb_done: got %b expected 110",
                  {if_m.done, if_m.data_out, if_m.frame_active});
      else n_pass++;
      cycle();
      n_checks++;
      if (if_m.done !== 1'b0) $display("FAIL msb_done_clear: got %b expected 0", if_m.done);
      else n_pass++;
      $display("msb frame 0x01 sent");
   endtask

   task automatic test_lsb_first();
      logic [7:0] words [2] = '{8'h01, 8'hA5};
      logic [7:0] seqs  [2] = '{8'b10000000, 8'b10100101};
      for (int f = 0; f < 2; f++) begin
         if_l.load_valid = 1; if_l.data_in = words[f]; if_l.shift_en = 1;
         cycle();
         if_l.load_valid = 0;
         for (int i = 0; i < 8; i++) begin
            n_checks++;
            if ({if_l.data_out, if_l.last_bit} !== {seqs[f][7-i], (i == 7)})
               $display("FAIL lsb_w%0d_bit%0d: got %b expected %b", f, i,
                        {if_l.data_out, if_l.last_bit}, {seqs[f][7-i], (i == 7)});
            else n_pass++;
            cycle();
         end
         n_checks++;
         if ({if_l.done, if_l.data_out} !== 2'b11)
            $display("FAIL lsb_w%0d_done: got %b expected 11", f, {if_l.done, if_l.data_out});
         else n_pass++;
         cycle();
         $display("lsb frame 0x%02h sent", words[f]);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp_seq = 16'b1111000000001111;
      if_m.load_valid = 1; if_m.data_in = 8'hF0; if_m.shift_en = 1;
      cycle();
      if_m.data_in = 8'h0F;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) if_m.load_valid = 0;
         n_checks++;
         if ({if_m.data_out, if_m.frame_active, if_m.load_ready, if_m.done} !==
             {exp_seq[15-i], 1'b1, (i == 7 || i == 15), (i == 8)})
            $display("FAIL b2b_bit%0d: got %b expected %b", i,
                     {if_m.data_out, if_m.frame_active, if_m.load_ready, if_m.done},
                     {exp_seq[15-i], 1'b1, (i == 7 || i == 15), (i == 8)});
         else n_pass++;
         cycle();
      end
      n_checks++;
      if ({if_m.done, if_m.frame_active} !== 2'b10)
         $display("FAIL b2b_done2: got %b expected 10", {if_m.done, if_m.frame_active});
      else n_pass++;
      cycle();
      $display("back-to-back frames 0xF0,0x0F sent");
   endtask

   task automatic test_strobe_gaps();
      logic [7:0] exp_seq = 8'b11000011;
      if_m.load_valid = 1; if_m.data_in = 8'hC3; if_m.shift_en = 0;
      cycle();
      if_m.load_valid = 0;
      for (int b = 0; b < 8; b++) begin
         for (int p = 0; p < 3; p++) begin
            if_m.shift_en = (p == 2);
            if (b == 2 && p == 0) begin
               if_m.load_valid = 1; if_m.data_in = 8'h55;
               #1;
               n_checks++;
               if (if_m.load_ready !== 1'b0)
                  $display("FAIL gap_busy_ready: got %b expected 0", if_m.load_ready);
               else n_pass++;
            end
            if (b == 2 && p == 2) if_m.load_valid = 0;
            n_checks++;
            if ({if_m.data_out, if_m.last_bit, if_m.done, if_m.frame_active} !==
                {exp_seq[7-b], (b == 7), 1'b0, 1'b1})
               $display("FAIL gap_bit%0d_ph%0d: got %b expected %b", b, p,
                        {if_m.data_out, if_m.last_bit, if_m.done, if_m.frame_active},
                        {exp_seq[7-b], (b == 7), 1'b0, 1'b1});
            else n_pass++;
            cycle();
         end
      end
      if_m.shift_en = 0;
      n_checks++;
      if ({if_m.done, if_m.frame_active, if_m.data_out} !== 3'b101)
         $display("FAIL gap_done: got %b expected 101",
                  {if_m.done, if_m.frame_active, if_m.data_out});
      else n_pass++;
      cycle();
      n_checks++;
      if (if_m.done !== 1'b0) $display("FAIL gap_done_clear: got %b expected 0", if_m.done);
      else n_pass++;
      $display("strobed frame 0xC3 sent");
   endtask

   task automatic test_abort();
      if_m.load_valid = 1; if_m.data_in = 8'hFF; if_m.shift_en = 1;
      cycle();
      if_m.load_valid = 0;
      repeat (3) cycle();
      if_m.abort = 1; if_m.load_valid = 1;
      #1;
      n_checks++;
      if (if_m.load_ready !== 1'b0)
         $display("FAIL abort_ready: got %b expected 0", if_m.load_ready);
      else n_pass++;
      cycle();
      if_m.abort = 0; if_m.load_valid = 0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({if_m.frame_active, if_m.data_out, if_m.done} !== 3'b010)
            $display("FAIL abort_idle%0d: got %b expected 010", i,
                     {if_m.frame_active, if_m.data_out, if_m.done});
         else n_pass++;
         cycle();
      end
      if_m.load_valid = 1; if_m.data_in = 8'h00;
      cycle();
      if_m.load_valid = 0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if ({if_m.data_out, if_m.frame_active} !== 2'b01)
            $display("FAIL abort_zero_bit%0d: got %b expected 01", i,
                     {if_m.data_out, if_m.frame_active});
         else n_pass++;
         cycle();
      end
      n_checks++;
      if (if_m.done !== 1'b1) $display("FAIL abort_zero_done: got %b expected 1", if_m.done);
      else n_pass++;
      cycle();
      $display("aborted 0xFF, then frame 0x00 sent");
   endtask

   task automatic test_async_reset();
      logic [7:0] exp_seq = 8'b10000001;
      if_m.load_valid = 1; if_m.data_in = 8'h00; if_m.shift_en = 1;
      cycle();
      if_m.load_valid = 0;
      repeat (3) cycle();
      #3;
      reset = 1;
      #1;
      n_checks++;
      if ({if_m.data_out, if_m.frame_active, if_m.done, if_m.last_bit} !== 4'b1000)
         $display("FAIL async_reset: got %b expected 1000",
                  {if_m.data_out, if_m.frame_active, if_m.done, if_m.last_bit});
      else n_pass++;
      cycle();
      reset = 0;
      #1;
      n_checks++;
      if ({if_m.load_ready, if_m.frame_active} !== 2'b10)
         $display("FAIL async_release: got %b expected 10", {if_m.load_ready, if_m.frame_active});
      else n_pass++;
      if_m.load_valid = 1; if_m.data_in = 8'h81;
      cycle();
      if_m.load_valid = 0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (if_m.data_out !== exp_seq[7-i])
            $display("FAIL async_81_bit%0d: got %b expected %b", i, if_m.data_out, exp_seq[7-i]);
         else n_pass++;
         cycle();
      end
      n_checks++;
      if (if_m.done !== 1'b1) $display("FAIL async_81_done: got %b expected 1", if_m.done);
      else n_pass++;
      cycle();
      $display("reset mid-frame, then frame 0x81 sent");
   endtask

   task automatic test_width2();
      logic [1:0] exp_seq = 2'b10;
      if_w.load_valid = 1; if_w.data_in = 2'b10; if_w.shift_en = 1;
      cycle();
      if_w.load_valid = 0;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if ({if_w.data_out, if_w.last_bit, if_w.done} !== {exp_seq[1-i], (i == 1), 1'b0})
            $display("FAIL w2_bit%0d: got %b expected %b", i,
                     {if_w.data_out, if_w.last_bit, if_w.done}, {exp_seq[1-i], (i == 1), 1'b0});
         else n_pass++;
         cycle();
      end
      n_checks++;
      if ({if_w.done, if_w.frame_active} !== 2'b10)
         $display("FAIL w2_done: got %b expected 10", {if_w.done, if_w.frame_active});
      else n_pass++;
      cycle();
      $display("width-2 frame 2'b10 sent");
   endtask

   initial begin
      test_reset();
      test_msb_basic();
      test_lsb_first();
      test_back_to_back();
      test_strobe_gaps();
      test_abort();
      test_async_reset();
      test_width2();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
